nios_accelerometer_paced_output: RTL and testbench

//  Parametrised successor to the single-register output PIO on the accelerometer Nios system.
//  - Avalon-MM slave (s1). Software pushes filtered samples into a FIFO.
//  - A programmable rate divider pops one sample per tick onto out_port, with a 1-cycle out_valid strobe.
//  - Downstream display/DAC logic therefore receives samples at a fixed rate, independent of CPU jitter.

---
 rtl/nios_accelerometer_paced_output.sv | 158 +++++++++++++++
 tb/tb_nios_accelerometer_paced_output.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_accelerometer_paced_output.sv
// Avalon-MM sample FIFO drained onto out_port at a programmable tick rate.
// Optional low-watermark interrupt: define NIOS_PACED_OUTPUT_IRQ_EN (reg 3 [3] irq_en, [15:8] threshold).
module nios_accelerometer_paced_output #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 24,
    parameter int DIV_RESET  = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    output logic                  irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, divider_q, divider_d;
    logic                  enable_q, enable_d, ovf_q, ovf_d, udr_q, udr_d;
    logic [DATA_WIDTH-1:0] outPort_q, outPort_d;
    logic                  outValid_q;

    logic wrEn, push, statusWr, divWr, ctrlWr, flush;
    logic empty, full, tick, pop, pushOk;
    logic unusedWdata;

    assign wrEn     = chipselect & ~write_n;
    assign push     = wrEn & (address == 2'd0);
    assign statusWr = wrEn & (address == 2'd1);
    assign divWr    = wrEn & (address == 2'd2);
    assign ctrlWr   = wrEn & (address == 2'd3);
    assign flush    = ctrlWr & writedata[1];

    assign empty  = (level_q == '0);
    assign full   = (level_q == FULL_LVL);
    // A flush in the same cycle suppresses the tick entirely (no pop, no underrun).
    assign tick   = enable_q & (cnt_q == divider_q) & ~flush;
    assign pop    = tick & ~empty;
    assign pushOk = push & (~full | pop);

    assign unusedWdata = ^writedata;

    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        level_d   = level_q;
        cnt_d     = cnt_q;
        divider_d = divider_q;
        enable_d  = enable_q;
        ovf_d     = ovf_q;
        udr_d     = udr_q;
        outPort_d = outPort_q;

        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            if (pushOk) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (pop)    rdPtr_d = rdPtr_q + PTR_W'(1);
            if (pushOk && !pop)      level_d = level_q + LVL_W'(1);
            else if (!pushOk && pop) level_d = level_q - LVL_W'(1);
        end

        if (pop) outPort_d = mem_q[rdPtr_q];

        if (flush || divWr || !enable_q || (cnt_q == divider_q)) cnt_d = '0;
        else                                                      cnt_d = cnt_q + DIV_WIDTH'(1);

        if (divWr)  divider_d = writedata[DIV_WIDTH-1:0];
        if (ctrlWr) enable_d  = writedata[0];

        if (push && full && !pop)           ovf_d = 1'b1;
        else if (statusWr && writedata[18]) ovf_d = 1'b0;

        if (tick && empty)                  udr_d = 1'b1;
        else if (statusWr && writedata[19]) udr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (pushOk) mem_q[wrPtr_q] <= writedata[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            divider_q  <= DIV_WIDTH'(DIV_RESET);
            enable_q   <= 1'b0;
            ovf_q      <= 1'b0;
            udr_q      <= 1'b0;
            outPort_q  <= '0;
            outValid_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            divider_q  <= divider_d;
            enable_q   <= enable_d;
            ovf_q      <= ovf_d;
            udr_q      <= udr_d;
            outPort_q  <= outPort_d;
            outValid_q <= pop;
        end
    end

    assign out_port  = outPort_q;
    assign out_valid = outValid_q;

    logic [31:0] ctrlRead;

`ifdef NIOS_PACED_OUTPUT_IRQ_EN
    logic       irqEn_q, irq_q;
    logic [7:0] thresh_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqEn_q  <= 1'b0;
            thresh_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrlWr) begin
                irqEn_q  <= writedata[3];
                thresh_q <= writedata[15:8];
            end
            irq_q <= irqEn_q & enable_q & (16'(level_q) <= 16'(thresh_q));
        end
    end

    assign irq      = irq_q;
    assign ctrlRead = {16'b0, thresh_q, 4'b0, irqEn_q, 2'b0, enable_q};
`else
    assign irq      = 1'b0;
    assign ctrlRead = {31'b0, enable_q};
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[DATA_WIDTH-1:0] = outPort_q;
            2'd1: readdata = {12'b0, udr_q, ovf_q, full, empty, 16'(level_q)};
            2'd2: readdata[DIV_WIDTH-1:0] = divider_q;
            default: readdata = ctrlRead;
        endcase
    end
endmodule

// File: tb/tb_nios_accelerometer_paced_output.sv
// Scoreboard bench for nios_accelerometer_paced_output: stimulus queues expected samples, a monitor checks each out_valid.
// Compile with +define+NIOS_PACED_OUTPUT_IRQ_EN to exercise the interrupt path instead of the tied-off variant.
module tb_nios_accelerometer_paced_output;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_port;
    logic        out_valid;
    logic        irq;

    int testsRun = 0;
    int testsFailed = 0;
    int cycle = 0;
    int validCount = 0;
    logic [31:0] expQ[$];
    int validCycles[$];

    nios_accelerometer_paced_output dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .out_valid(out_valid), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every out_valid must match the oldest outstanding expected sample.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1) begin
            validCount++;
            validCycles.push_back(cycle);
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected out_valid: got out_port 0x%08h, expected no output", out_port);
            end else begin
                checkOutput("out_port", out_port, expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1 data = readdata;
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic checkReg(input string name, input logic [1:0] addr, input logic [31:0] expected);
        logic [31:0] value;
        readReg(addr, value);
        checkOutput(name, value, expected);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitValid(input int target, input int limit);
        int k = 0;
        while (validCount < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (validCount < target) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL waitValid timeout: got %0d strobes, expected %0d", validCount, target);
        end
    endtask

    initial begin
        int base;
        int n;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        checkOutput("reset out_port", out_port, 32'h0);
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("reset irq", {31'b0, irq}, 32'h0);
        checkReg("reset reg0", 2'd0, 32'h0);
        checkReg("reset reg1", 2'd1, 32'h0001_0000);
        checkReg("reset reg2", 2'd2, 32'd50000);
        checkReg("reset reg3", 2'd3, 32'h0);

        // Paced drain with divider=3: period of 4 cycles, then underrun.
        applyStimulus(2'd2, 32'd3);
        foreach (expQ[i]) ;
        applyStimulus(2'd0, 32'hA); expQ.push_back(32'hA);
        applyStimulus(2'd0, 32'hB); expQ.push_back(32'hB);
        applyStimulus(2'd0, 32'hC); expQ.push_back(32'hC);
        checkReg("level after 3 pushes", 2'd1, 32'h0000_0003);
        base = validCount;
        applyStimulus(2'd3, 32'h1);
        waitValid(base + 3, 60);
        idle(6);
        checkReg("udr after drain", 2'd1, 32'h0009_0000);
        n = validCycles.size();
        if (n >= 3) begin
            checkOutput("gap div3 a", 32'(validCycles[n-2] - validCycles[n-3]), 32'd4);
            checkOutput("gap div3 b", 32'(validCycles[n-1] - validCycles[n-2]), 32'd4);
        end
        checkOutput("out_port holds last", out_port, 32'hC);
        applyStimulus(2'd3, 32'h0);
        applyStimulus(2'd1, 32'h0008_0000);
        checkReg("udr cleared", 2'd1, 32'h0001_0000);

        // Overflow: 17 pushes into a 16-deep FIFO while disabled.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(2'd0, 32'h100 + 32'(i));
            if (i < 16) expQ.push_back(32'h100 + 32'(i));
        end
        checkReg("full with ovf", 2'd1, 32'h0006_0010);
        applyStimulus(2'd1, 32'h0004_0000);
        checkReg("ovf cleared", 2'd1, 32'h0002_0010);

        // Full FIFO, divider=0: push lands on a tick so both succeed.
        applyStimulus(2'd2, 32'd0);
        base = validCount;
        applyStimulus(2'd3, 32'h1);
        applyStimulus(2'd0, 32'h200); expQ.push_back(32'h200);
        checkReg("full push+pop", 2'd1, 32'h0002_0010);
        waitValid(base + 17, 60);
        n = validCycles.size();
        if (n >= 2) checkOutput("gap div0", 32'(validCycles[n-1] - validCycles[n-2]), 32'd1);
        applyStimulus(2'd3, 32'h0);
        checkReg("reg0 last sample", 2'd0, 32'h200);
        applyStimulus(2'd1, 32'h0008_0000);
        checkReg("empty after drain", 2'd1, 32'h0001_0000);

        // Flush discards queued words without touching out_port.
        for (int i = 0; i < 5; i++) applyStimulus(2'd0, 32'h300 + 32'(i));
        checkReg("level 5", 2'd1, 32'h0000_0005);
        applyStimulus(2'd3, 32'h2);
        checkReg("flushed", 2'd1, 32'h0001_0000);
        checkReg("flush reads 0", 2'd3, 32'h0);
        idle(3);
        checkOutput("out_port after flush", out_port, 32'h200);

`ifdef NIOS_PACED_OUTPUT_IRQ_EN
        applyStimulus(2'd2, 32'd9);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'd0, 32'h400 + 32'(i));
            expQ.push_back(32'h400 + 32'(i));
        end
        base = validCount;
        applyStimulus(2'd3, 32'h0000_0209);
        checkOutput("irq low at level 4", {31'b0, irq}, 32'h0);
        checkReg("reg3 irq fields", 2'd3, 32'h0000_0209);
        waitValid(base + 2, 40);
        idle(2);
        checkOutput("irq after 2nd pop", {31'b0, irq}, 32'h1);
        applyStimulus(2'd0, 32'h404); expQ.push_back(32'h404);
        idle(1);
        checkOutput("irq after refill", {31'b0, irq}, 32'h0);
        applyStimulus(2'd3, 32'h0);
        applyStimulus(2'd3, 32'h2);
        expQ.delete();
`else
        applyStimulus(2'd3, 32'h0000_FF09);
        checkReg("reg3 ignores irq bits", 2'd3, 32'h0000_0001);
        applyStimulus(2'd3, 32'h0);
        checkOutput("irq tied low", {31'b0, irq}, 32'h0);
`endif

        // Reset mid-stream discards the FIFO and restores reset values at once.
        applyStimulus(2'd2, 32'd5);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'd0, 32'h500 + 32'(i));
            expQ.push_back(32'h500 + 32'(i));
        end
        base = validCount;
        applyStimulus(2'd3, 32'h1);
        waitValid(base + 1, 40);
        idle(1);
        reset_n = 1'b0;
        expQ.delete();
        address = 2'd2;
        #1;
        checkOutput("midreset out_port", out_port, 32'h0);
        checkOutput("midreset out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("midreset irq", {31'b0, irq}, 32'h0);
        checkOutput("midreset reg2", readdata, 32'd50000);
        address = 2'd1;
        #1;
        checkOutput("midreset reg1", readdata, 32'h0001_0000);
        @(negedge clk);
        reset_n = 1'b1;
        base = validCount;
        idle(20);
        checkOutput("no output after reset", 32'(validCount - base), 32'd0);
        checkReg("post reset reg1", 2'd1, 32'h0001_0000);

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
